// File: rtl/pit_cmd_sequencer.sv
// Host-side command sequencer for an 8253 PIT: expands one program or
// latch+read command into control-word, data-write and data-read bus cycles.
module pit_cmd_sequencer #(
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned GAP_CYC    = 2
) (
    input  logic        zclk,
    input  logic        rst_n,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic        cmd_op,
    input  logic [1:0]  cmd_chan,
    input  logic [1:0]  cmd_rw,
    input  logic [2:0]  cmd_mode,
    input  logic [15:0] cmd_count,
    output logic        rsp_valid,
    output logic        rsp_err,
    output logic [15:0] rsp_data,
    output logic        pit_cs_n,
    output logic        pit_a1,
    output logic        pit_a0,
    output logic        pit_wr_n,
    output logic        pit_rd_n,
    output logic [7:0]  pit_dout,
    output logic        pit_doe,
    input  logic [7:0]  pit_din
);

    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] GAP_LD    = 4'(GAP_CYC - 1);

    typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, GAP, DONE} state_t;

    state_t      state;
    state_t      state_nxt;

    logic        op_q;
    logic [1:0]  chan_q;
    logic [1:0]  rw_q;
    logic [2:0]  mode_q;
    logic [15:0] count_q;
    logic [1:0]  idx;
    logic [3:0]  timer;
    logic [7:0]  lsb_q;
    logic [7:0]  msb_q;

    logic [1:0]  last_idx;
    logic        acc_wr;
    logic [1:0]  acc_addr;
    logic [7:0]  acc_data;
    logic        bus_on;

    // Decode the current access (direction, address, write byte) from the latched command
    always_comb begin
        acc_wr   = 1'b1;
        acc_addr = chan_q;
        acc_data = '0;
        last_idx = 2'd2;
        if (!op_q) begin
            case (rw_q)
                2'b00:   last_idx = 2'd0;
                2'b11:   last_idx = 2'd2;
                default: last_idx = 2'd1;
            endcase
        end
        if (idx == 2'd0) begin
            acc_addr = 2'b11;
            acc_data = op_q ? {chan_q, 6'b000000} : {chan_q, rw_q, mode_q, 1'b0};
        end else if (op_q) begin
            acc_wr = 1'b0;
        end else begin
            // Second access carries MSB only when rw selects MSB alone
            acc_data = (idx == 2'd1 && rw_q != 2'b10) ? count_q[7:0] : count_q[15:8];
        end
    end

    // State register
    always_ff @(posedge zclk) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next-state and bus/handshake output decode
    always_comb begin
        state_nxt = state;
        bus_on    = 1'b0;
        pit_wr_n  = 1'b1;
        pit_rd_n  = 1'b1;
        case (state)
            IDLE:   if (cmd_valid) state_nxt = (cmd_chan == 2'd3) ? DONE : SETUP;
            SETUP:  begin
                bus_on    = 1'b1;
                state_nxt = STROBE;
            end
            STROBE: begin
                bus_on   = 1'b1;
                pit_wr_n = !acc_wr;
                pit_rd_n = acc_wr;
                if (timer == 4'd0) state_nxt = HOLD;
            end
            HOLD:   begin
                bus_on    = 1'b1;
                state_nxt = GAP;
            end
            GAP:    if (timer == 4'd0) state_nxt = (idx == last_idx) ? DONE : SETUP;
            DONE:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
        pit_cs_n  = !bus_on;
        pit_a1    = bus_on & acc_addr[1];
        pit_a0    = bus_on & acc_addr[0];
        pit_doe   = bus_on & acc_wr;
        pit_dout  = pit_doe ? acc_data : '0;
        cmd_ready = (state == IDLE);
        rsp_valid = (state == DONE);
    end

    // Command latch, phase timer, access index, read capture and response registers
    always_ff @(posedge zclk) begin
        if (!rst_n) begin
            op_q     <= 1'b0;
            chan_q   <= '0;
            rw_q     <= '0;
            mode_q   <= '0;
            count_q  <= '0;
            idx      <= '0;
            timer    <= '0;
            lsb_q    <= '0;
            msb_q    <= '0;
            rsp_err  <= 1'b0;
            rsp_data <= '0;
        end else begin
            case (state)
                IDLE: if (cmd_valid) begin
                    op_q    <= cmd_op;
                    chan_q  <= cmd_chan;
                    rw_q    <= cmd_rw;
                    mode_q  <= cmd_mode;
                    count_q <= cmd_count;
                    idx     <= '0;
                    if (cmd_chan == 2'd3) begin
                        rsp_err  <= 1'b1;
                        rsp_data <= '0;
                    end
                end
                SETUP:  timer <= STROBE_LD;
                STROBE: begin
                    if (timer == 4'd0) begin
                        if (!acc_wr) begin
                            if (idx == 2'd1) lsb_q <= pit_din;
                            else             msb_q <= pit_din;
                        end
                    end else begin
                        timer <= timer - 4'd1;
                    end
                end
                HOLD:   timer <= GAP_LD;
                GAP: begin
                    if (timer != 4'd0) begin
                        timer <= timer - 4'd1;
                    end else if (idx != last_idx) begin
                        idx <= idx + 2'd1;
                    end else begin
                        rsp_err  <= 1'b0;
                        rsp_data <= op_q ? {msb_q, lsb_q} : 16'h0000;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/pit_cmd_sequencer.md
Name: pit_cmd_sequencer

Overview:
- Host-side controller that programs and reads back the intel8253 timer over its 8-bit bus.
- Accepts one high-level command at a time: "program channel N with mode M and count C", or "latch and read channel N".
- Expands each command into the required control-word write, data write and read cycles on the cs_n/a1/a0/wr_n/rd_n/d pins.
- Sits between the BIOS/bus glue and the 8253. It runs on the same system clock as the 8253 register logic.

Parameters:
- STROBE_CYC, 2: cycles wr_n/rd_n held low per access; legal values 2..15.
- GAP_CYC, 2: cycles cs_n held high between accesses; legal values 2..15.

Ports:
- zclk  input  1  system clock; all logic on rising edge.
- rst_n  input  1  synchronous active-low reset, sampled on rising zclk.
- cmd_valid  input  1  command request.
- cmd_ready  output  1  high only in IDLE; the command is accepted on a rising edge with cmd_valid&cmd_ready.
- cmd_op  input  1  0 = program, 1 = latch+read.
- cmd_chan  input  2  channel 0..2; 3 is illegal.
- cmd_rw  input  2  program op only: 00 latch-only, 01 LSB, 10 MSB, 11 LSB then MSB.
- cmd_mode  input  3  program op only: 8253 mode field.
- cmd_count  input  16  program op only: count value.
- rsp_valid  output  1  one-cycle pulse when a command completes.
- rsp_err  output  1  valid with rsp_valid; 1 = illegal channel.
- rsp_data  output  16  valid with rsp_valid; {MSB,LSB} for a read, 0 otherwise.
- pit_cs_n  output  1  8253 chip select.
- pit_a1  output  1  8253 address bit 1.
- pit_a0  output  1  8253 address bit 0.
- pit_wr_n  output  1  8253 write strobe.
- pit_rd_n  output  1  8253 read strobe.
- pit_dout  output  8  data to 8253.
- pit_doe  output  1  drive enable for pit_dout; the top level tristates the bus with it.
- pit_din  input  8  data from 8253.

Behaviour:
- Reset: state IDLE, cmd_ready=1, rsp_valid=0, rsp_err=0, rsp_data=0, pit_cs_n=1, pit_wr_n=1, pit_rd_n=1, a1=a0=0, pit_dout=0, pit_doe=0.
- Reset asserted mid-command: the bus returns to idle values on the next edge. The command is dropped and no rsp_valid is generated.
- Command latching: on acceptance, all cmd_* fields are registered. Later input changes are ignored until the next IDLE.
- Access list, program op:
  - CW = {chan, rw, mode, 0}, written to a1a0=11.
  - Then per rw: 01 writes LSB to a1a0=chan; 10 writes MSB; 11 writes LSB then MSB; 00 writes CW only.
- Access list, read op:
  - CW = {chan, 00, 0000} to a1a0=11 (latch).
  - Read at a1a0=chan gives LSB.
  - Read at a1a0=chan gives MSB.
- Illegal channel (chan=3): no bus activity. The cycle after acceptance is DONE with rsp_err=1 and rsp_data=0.
- Bus access phases, for each access in order:
  - SETUP: 1 cycle. cs_n=0, a1/a0 valid, strobes high. For writes, pit_doe=1 and pit_dout valid.
  - STROBE: STROBE_CYC cycles. wr_n=0 (write) or rd_n=0 (read). Address, data and doe stable.
  - HOLD: 1 cycle. Strobes high; cs_n, address, data and doe unchanged.
  - GAP: GAP_CYC cycles. cs_n=1, doe=0, a1=a0=0, dout=0.
- Read capture: pit_din is sampled on the last STROBE cycle's rising edge, into a byte register for LSB or MSB.
- Strobe exclusivity: wr_n and rd_n are never low in the same cycle. pit_doe=0 whenever rd_n=0.
- Sequencing:
  - States: IDLE -> SETUP -> STROBE -> HOLD -> GAP -> (SETUP of the next access | DONE) -> IDLE.
  - The access index is a 2-bit counter. The phase timer is a 4-bit down-counter.
- DONE: 1 cycle. rsp_valid=1 plus rsp_err/rsp_data; cmd_ready=0. The next cycle is IDLE with cmd_ready=1.
- Latency:
  - With N accesses, rsp_valid is high exactly N*(2+STROBE_CYC+GAP_CYC)+1 cycles after the acceptance edge.
  - Back-to-back commands are therefore separated by at least 1 IDLE cycle.
- rsp_data/rsp_err hold their values until the next DONE or reset.

Test Plan:
- Reset, then chan=0, op=0, rw=11, mode=011, count=0x1234 (S=G=2) -> CW 0x36 to a1a0=11, then 0x34 and 0x12 to a1a0=00. Each wr_n low exactly 2 cycles; rsp_valid at cycle 19, rsp_err=0.
- Read chan=2 with pit_din=0xCD during the LSB strobe and 0xAB during the MSB strobe -> CW 0x80 written, two rd_n pulses at a1a0=10, rsp_data=0xABCD, never wr_n&rd_n low together.
- Program chan=1 rw=01 mode=000 count=0x00FF -> CW 0x50 then 0xFF at a1a0=01; only 2 accesses; rsp_valid at cycle 13.
- chan=3 command -> pit_cs_n stays 1 throughout; rsp_valid at cycle 1 with rsp_err=1, rsp_data=0.
- rst_n low during the STROBE of the second access -> next edge: cs_n=wr_n=1, doe=0, cmd_ready=1, no rsp_valid; a following command runs normally.
- cmd_valid held high continuously with changing cmd_count -> the second command is accepted only in IDLE after DONE, and the first command's bytes match the value latched at its acceptance.
